ifu_fetch_ctrl: RTL and testbench

- Single-issue fetch sequencer; owns the architectural PC.
- Issues instruction-memory requests over a valid/ready pair and captures the response.
- Hands the instruction to the decoder over valid/ready.
- Waits for EXU completion, then computes next PC from EXU increment/override inputs (branch/JAL/JALR semantics).
- Sits between instruction memory, IDU and EXU; replaces a free-running PC register.

---
 rtl/ifu_pkg.sv | 14 +
 rtl/ifu_fetch_ctrl_if.sv | 33 +++
 rtl/ifu_npc.sv | 20 ++
 rtl/ifu_fetch_ctrl.sv | 107 ++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_RESP  = 2'd1,
    S_ISSUE = 2'd2,
    S_EXEC  = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// rtl/ifu_fetch_ctrl_if.sv - fetch controller bus: imem request/response and IDU instruction handoff
interface ifu_fetch_ctrl_if #(
  parameter int XLEN = ifu_pkg::XLEN
) ();

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic            imem_resp_ready;
  logic [31:0]     imem_resp_data;
  logic            imem_resp_err;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_err;

  modport master (
    output imem_req_valid, imem_req_addr, imem_resp_ready,
    output inst_valid, inst, inst_pc, inst_err,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, imem_resp_ready,
    input  inst_valid, inst, inst_pc, inst_err,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    output inst_ready
  );

endinterface

// File: rtl/ifu_npc.sv
// rtl/ifu_npc.sv - next-PC calculator: base select, add increment, clear bit 0 on register-relative jumps
module ifu_npc #(
  parameter int XLEN = ifu_pkg::XLEN
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] inc,
  input  logic            ovrd,
  input  logic [XLEN-1:0] ovrd_addr,
  output logic [XLEN-1:0] next_pc
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] sum;

  assign base = ovrd ? ovrd_addr : pc;
  assign sum  = base + inc;
  // Only bit 0 is forced; any bit-1 misalignment is left for the fetch FSM to trap.
  assign next_pc = {sum[XLEN-1:1], sum[0] & ~ovrd};

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// rtl/ifu_fetch_ctrl.sv - single-issue fetch sequencer owning the architectural PC
module ifu_fetch_ctrl #(
  parameter int              XLEN     = ifu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = ifu_pkg::DEF_RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  ifu_fetch_ctrl_if.master    bus,
  input  logic                exe_done,
  input  logic [XLEN-1:0]     exe_inc,
  input  logic                exe_ovrd,
  input  logic [XLEN-1:0]     exe_ovrd_addr,
  output logic [XLEN-1:0]     pc,
  output logic [63:0]         retire_cnt
);

  import ifu_pkg::*;

  ifu_state_e      state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] next_pc;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            inst_err_q;
  logic [63:0]     retire_q;
  logic            req_valid_q;
  logic            resp_ready_q;
  logic            inst_valid_q;

  ifu_npc #(.XLEN(XLEN)) u_npc (
    .pc        (pc_q),
    .inc       (exe_inc),
    .ovrd      (exe_ovrd),
    .ovrd_addr (exe_ovrd_addr),
    .next_pc   (next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_REQ;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= RESET_PC;
      inst_err_q   <= 1'b0;
      retire_q     <= '0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (pc_q[1:0] != 2'b00) begin
            inst_q       <= '0;
            inst_pc_q    <= pc_q;
            inst_err_q   <= 1'b1;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b1;
            state        <= S_ISSUE;
          end else if (!req_valid_q) begin
            // Only reached on the first cycle out of reset; later entries arrive with valid already set.
            req_valid_q <= 1'b1;
          end else if (bus.imem_req_ready) begin
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b1;
            state        <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.imem_resp_valid) begin
            inst_q       <= bus.imem_resp_err ? 32'h0 : bus.imem_resp_data;
            inst_pc_q    <= pc_q;
            inst_err_q   <= bus.imem_resp_err;
            resp_ready_q <= 1'b0;
            inst_valid_q <= 1'b1;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.inst_ready) begin
            inst_valid_q <= 1'b0;
            state        <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exe_done) begin
            pc_q        <= next_pc;
            retire_q    <= retire_q + 64'd1;
            req_valid_q <= (next_pc[1:0] == 2'b00);
            state       <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  assign bus.imem_req_valid  = req_valid_q;
  assign bus.imem_req_addr   = pc_q;
  assign bus.imem_resp_ready = resp_ready_q;
  assign bus.inst_valid      = inst_valid_q;
  assign bus.inst            = inst_q;
  assign bus.inst_pc         = inst_pc_q;
  assign bus.inst_err        = inst_err_q;
  assign pc                  = pc_q;
  assign retire_cnt          = retire_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb/tb_ifu_fetch_ctrl.sv - directed self-checking bench for ifu_fetch_ctrl
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exe_done;
  logic [31:0] exe_inc;
  logic        exe_ovrd;
  logic [31:0] exe_ovrd_addr;
  logic [31:0] pc;
  logic [63:0] retire_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_hs = 0;
  int hs_gap = 0;
  int req_cnt = 0;
  int iss_cnt = 0;

  always #5 clk = ~clk;

  ifu_fetch_ctrl_if #(.XLEN(32)) bus ();

  ifu_fetch_ctrl #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .exe_done      (exe_done),
    .exe_inc       (exe_inc),
    .exe_ovrd      (exe_ovrd),
    .exe_ovrd_addr (exe_ovrd_addr),
    .pc            (pc),
    .retire_cnt    (retire_cnt)
  );

  always @(posedge clk) begin
    cyc++;
    if (!rst && bus.imem_req_valid && bus.imem_req_ready) begin
      hs_gap  = cyc - last_hs;
      last_hs = cyc;
      req_cnt++;
    end
    if (!rst && bus.inst_valid && bus.inst_ready) iss_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.imem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_wait", bus.imem_req_valid, 1);
  endtask

  // Request phase through response capture; memory offers the response already in the request cycle.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input logic err,
                       input int req_stall);
    wait_req();
    chk("req_addr", bus.imem_req_addr, addr);
    repeat (req_stall) begin
      bus.imem_req_ready = 1'b0;
      @(negedge clk);
      chk("req_hold", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, addr});
    end
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = data;
    bus.imem_resp_err   = err;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    chk("resp_state", {bus.imem_resp_ready, bus.inst_valid, bus.imem_req_valid}, 3'b100);
    @(negedge clk);
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.imem_resp_err   = 1'b0;
  endtask

  task automatic issue_exec(input logic [31:0] e_inst, input logic [31:0] e_ipc, input logic e_err,
                            input int stall, input logic spurious,
                            input logic [31:0] inc, input logic ovrd, input logic [31:0] oaddr,
                            input logic [31:0] e_next, input logic [63:0] e_ret);
    chk("inst_valid", bus.inst_valid, 1);
    chk("inst", {bus.inst_err, bus.inst}, {e_err, e_inst});
    chk("inst_pc", bus.inst_pc, e_ipc);
    repeat (stall) begin
      bus.inst_ready = 1'b0;
      exe_done = spurious;
      exe_inc  = 32'd4;
      @(negedge clk);
      chk("issue_hold", {bus.inst_valid, bus.inst_err, bus.inst, bus.inst_pc}, {1'b1, e_err, e_inst, e_ipc});
      chk("pc_hold", {retire_cnt[31:0], pc}, {e_ret[31:0] - 32'd1, e_ipc});
    end
    exe_done = 1'b0;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    chk("exec_entry", {bus.inst_valid, bus.imem_req_valid}, 2'b00);
    exe_done      = 1'b1;
    exe_inc       = inc;
    exe_ovrd      = ovrd;
    exe_ovrd_addr = oaddr;
    @(negedge clk);
    exe_done = 1'b0;
    exe_ovrd = 1'b0;
    chk("next_pc", pc, e_next);
    chk("retire", retire_cnt, e_ret);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int i0;
    int n;
    exe_done = 1'b0; exe_inc = 32'd4; exe_ovrd = 1'b0; exe_ovrd_addr = 32'h0;
    bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = 32'h0; bus.imem_resp_err = 1'b0; bus.inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valids", {bus.imem_req_valid, bus.imem_resp_ready, bus.inst_valid}, 3'b000);
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_retire", retire_cnt, 64'd0);
    chk("rst_inst", {bus.inst_err, bus.inst}, 33'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h8000_0000);
    rst = 1'b0;

    fetch(32'h8000_0000, 32'h0000_0013, 1'b0, 0);
    issue_exec(32'h0000_0013, 32'h8000_0000, 1'b0, 0, 1'b0, 32'd4, 1'b0, 32'h0, 32'h8000_0004, 64'd1);
    fetch(32'h8000_0004, 32'h0010_0093, 1'b0, 0);
    chk("gap_1", hs_gap, 4);
    issue_exec(32'h0010_0093, 32'h8000_0004, 1'b0, 0, 1'b0, 32'd4, 1'b0, 32'h0, 32'h8000_0008, 64'd2);
    fetch(32'h8000_0008, 32'h0020_0113, 1'b0, 0);
    chk("gap_2", hs_gap, 4);
    issue_exec(32'h0020_0113, 32'h8000_0008, 1'b0, 0, 1'b0, 32'd4, 1'b0, 32'h0, 32'h8000_000C, 64'd3);
    fetch(32'h8000_000C, 32'h0000_0013, 1'b0, 0);
    issue_exec(32'h0000_0013, 32'h8000_000C, 1'b0, 0, 1'b0, 32'd4, 1'b0, 32'h0, 32'h8000_0010, 64'd4);

    // JALR: 0x80001001 + 4 = 0x80001005, bit 0 dropped
    fetch(32'h8000_0010, 32'h0000_8067, 1'b0, 0);
    issue_exec(32'h0000_8067, 32'h8000_0010, 1'b0, 0, 1'b0, 32'd4, 1'b1, 32'h8000_1001, 32'h8000_1004, 64'd5);

    r0 = req_cnt;
    i0 = iss_cnt;
    fetch(32'h8000_1004, 32'h1234_5678, 1'b0, 5);
    issue_exec(32'h1234_5678, 32'h8000_1004, 1'b0, 3, 1'b0, 32'd2, 1'b1, 32'h7FFF_FFFE, 32'h8000_0000, 64'd6);
    chk("bp_req_count", req_cnt - r0, 1);
    chk("bp_issue_count", iss_cnt - i0, 1);

    fetch(32'h8000_0000, 32'h0000_0013, 1'b0, 0);
    issue_exec(32'h0000_0013, 32'h8000_0000, 1'b0, 0, 1'b0, 32'd2, 1'b0, 32'h0, 32'h8000_0002, 64'd7);
    r0 = req_cnt;
    chk("mis_no_req_valid", bus.imem_req_valid, 0);
    n = 0;
    while (!bus.inst_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mis_no_req", req_cnt - r0, 0);
    issue_exec(32'h0, 32'h8000_0002, 1'b1, 0, 1'b0, 32'd0, 1'b1, 32'h8000_0100, 32'h8000_0100, 64'd8);

    fetch(32'h8000_0100, 32'hDEAD_BEEF, 1'b1, 0);
    issue_exec(32'h0, 32'h8000_0100, 1'b1, 2, 1'b1, 32'd4, 1'b0, 32'h0, 32'h8000_0104, 64'd9);

    wait_req();
    chk("pre_rst_addr", bus.imem_req_addr, 32'h8000_0104);
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    chk("pre_rst_resp", bus.imem_resp_ready, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_valids", {bus.imem_req_valid, bus.imem_resp_ready, bus.inst_valid}, 3'b000);
    chk("async_pc", pc, 32'h8000_0000);
    chk("async_retire", retire_cnt, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    fetch(32'h8000_0000, 32'h0000_0013, 1'b0, 0);
    issue_exec(32'h0000_0013, 32'h8000_0000, 1'b0, 0, 1'b0, 32'd4, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 64'd1);
    fetch(32'hFFFF_FFFC, 32'h0000_0013, 1'b0, 0);
    issue_exec(32'h0000_0013, 32'hFFFF_FFFC, 1'b0, 0, 1'b0, 32'd4, 1'b0, 32'h0, 32'h0000_0000, 64'd2);
    wait_req();
    chk("wrap_addr", bus.imem_req_addr, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
